// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
//   Shared AXI3 encodings and FSM state types for the axi_sram_slave block.
//   Contents:
//     - burst type encodings (FIXED / INCR / WRAP)
//     - response encodings (OKAY / SLVERR) and the one supported beat size
//     - read and write channel state enums
//     - req_ok(): size/burst legality test shared by both channels
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [0:0] {
    RD_IDLE,
    RD_BURST
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_e;

  // Only full-word beats with FIXED or INCR bursts are served normally.
  // Everything else is still accepted but answered with SLVERR.
  function automatic logic req_ok(input logic [2:0] size, input logic [1:0] burst);
    return (size == SIZE_4B) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

endpackage

// File: rtl/sram_1r1w.sv
// -----------------------------------------------------------------------------
// sram_1r1w
//   Synchronous one-read / one-write word SRAM, 32-bit words, per-byte write
//   enables. A read and a write to the same word on the same edge return the
//   old contents (read-before-write). Written so FPGA tools map it to BRAM.
//   Ports:
//     clk            clock
//     re, raddr      read enable / word address; rdata valid the cycle after
//     rdata          registered read data, held while re is low
//     we, waddr      write enable / word address
//     wdata, wstrb   write data and byte enables
// -----------------------------------------------------------------------------
module sram_1r1w #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  // NOTE: the array and its output register carry no reset: a reset port on
  // them would stop BRAM inference, and stale contents are harmless here.
  // NOTE: non-blocking assignments make the read sample mem before this
  // edge's write lands, which is exactly the read-before-write behaviour.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[raddr];
    end
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//   AXI3 responder backed by an on-chip word SRAM (2^MEM_AW x 32 bits).
//   Independent read and write FSMs, one outstanding transaction each.
//   Illegal requests (size != 4 bytes, WRAP/reserved burst, len > MAX_LEN-1)
//   are served as INCR for their full length and answered with SLVERR; their
//   writes are suppressed.
//   Ports:
//     aclk, aresetn                         clock, async active-low reset
//     ar*  / r*                             read address / read data channels
//     aw*  / w* / b*                        write address / data / response
//   Build option:
//     AXI_SLAVE_STALL_EN  when defined, a 16-bit LFSR randomly withholds
//                         arready/awready/wready (lfsr[0]) and delays the
//                         presentation of new read beats (lfsr[1]).
// -----------------------------------------------------------------------------
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int MEM_AW  = 14,
  parameter int MAX_LEN = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN - 1);

  // ---------------------------------------------------------------------------
  // Stall generator
  // ---------------------------------------------------------------------------
  logic addr_block;  // withhold arready/awready/wready next cycle
  logic rv_block;    // withhold presentation of a new read beat next cycle

`ifdef AXI_SLAVE_STALL_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;

  // Taps 16,14,13,11: maximal length. lfsr_d is the value the LFSR holds in
  // the cycle the registered handshake outputs become visible.
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign addr_block = lfsr_d[0];
  assign rv_block   = lfsr_d[1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
`else
  assign addr_block = 1'b0;
  assign rv_block   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // SRAM
  // ---------------------------------------------------------------------------
  logic              sram_re, sram_we;
  logic [MEM_AW-1:0] sram_raddr, sram_waddr;
  logic [31:0]       sram_rdata;

  sram_1r1w #(.AW(MEM_AW)) u_sram (
    .clk   (aclk),
    .re    (sram_re),
    .raddr (sram_raddr),
    .rdata (sram_rdata),
    .we    (sram_we),
    .waddr (sram_waddr),
    .wdata (wdata),
    .wstrb (wstrb)
  );

  // Address bits outside the word index and the write-data ID are ignored.
  logic unused_bits;
  assign unused_bits = ^{wid, araddr[31:MEM_AW+2], araddr[1:0],
                         awaddr[31:MEM_AW+2], awaddr[1:0]};

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [3:0]        rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [MEM_AW-1:0] raddr_q, raddr_d, raddr_nxt;
  logic [7:0]        rlen_q, rlen_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic              rfixed_q, rfixed_d;
  logic              ar_err;

  assign ar_err    = !req_ok(arsize, arburst) || (arlen > LEN_MAX);
  assign raddr_nxt = rfixed_q ? raddr_q : raddr_q + MEM_AW'(1);

  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rcnt_d     = rcnt_q;
    rfixed_d   = rfixed_q;
    sram_re    = 1'b0;
    sram_raddr = raddr_q;

    case (rd_state_q)
      RD_IDLE: begin
        arready_d = !addr_block;
        if (arvalid && arready_q) begin
          // First beat's SRAM read goes out on the handshake edge itself.
          sram_re    = 1'b1;
          sram_raddr = araddr[MEM_AW+1:2];
          raddr_d    = araddr[MEM_AW+1:2];
          rid_d      = arid;
          rlen_d     = arlen;
          rcnt_d     = 8'd0;
          rresp_d    = ar_err ? RESP_SLVERR : RESP_OKAY;
          rfixed_d   = (arburst == BURST_FIXED) && !ar_err;
          rlast_d    = (arlen == 8'd0);
          rvalid_d   = !rv_block;
          arready_d  = 1'b0;
          rd_state_d = RD_BURST;
        end
      end

      RD_BURST: begin
        if (!rvalid_q) begin
          // Beat fetched but held back by the stall generator.
          rvalid_d = !rv_block;
        end else if (rready) begin
          if (rlast_q) begin
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            arready_d  = !addr_block;
            rd_state_d = RD_IDLE;
          end else begin
            // Fetch the next beat on the accepting edge for full throughput.
            // Without a handshake nothing is re-read, so rdata holds.
            sram_re    = 1'b1;
            sram_raddr = raddr_nxt;
            raddr_d    = raddr_nxt;
            rcnt_d     = rcnt_q + 8'd1;
            rlast_d    = ((rcnt_q + 8'd1) == rlen_q);
            rvalid_d   = !rv_block;
          end
        end
      end

      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rcnt_q     <= '0;
      rfixed_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rcnt_q     <= rcnt_d;
      rfixed_q   <= rfixed_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rresp   = rresp_q;
  // The SRAM output register is not reset, so it is masked outside a beat.
  assign rdata   = rvalid_q ? sram_rdata : 32'd0;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wr_state_e         wr_state_q, wr_state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [3:0]        bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [MEM_AW-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              werr_q, werr_d;
  logic              wfixed_q, wfixed_d;
  logic              wmis_q, wmis_d;
  logic              aw_err, w_hs, last_mis;

  assign aw_err   = !req_ok(awsize, awburst) || (awlen > LEN_MAX);
  assign w_hs     = (wr_state_q == WR_DATA) && wvalid && wready_q;
  // wlast on the wrong beat, or the expected last beat without wlast.
  assign last_mis = wlast != (wcnt_q == wlen_q);

  assign sram_we    = w_hs && !werr_q;
  assign sram_waddr = waddr_q;

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wcnt_d     = wcnt_q;
    werr_d     = werr_q;
    wfixed_d   = wfixed_q;
    wmis_d     = wmis_q;

    case (wr_state_q)
      WR_IDLE: begin
        awready_d = !addr_block;
        if (awvalid && awready_q) begin
          waddr_d    = awaddr[MEM_AW+1:2];
          bid_d      = awid;
          wlen_d     = awlen;
          wcnt_d     = 8'd0;
          werr_d     = aw_err;
          wfixed_d   = (awburst == BURST_FIXED) && !aw_err;
          wmis_d     = 1'b0;
          awready_d  = 1'b0;
          wready_d   = !addr_block;
          wr_state_d = WR_DATA;
        end
      end

      WR_DATA: begin
        wready_d = !addr_block;
        if (w_hs) begin
          waddr_d = wfixed_q ? waddr_q : waddr_q + MEM_AW'(1);
          wcnt_d  = wcnt_q + 8'd1;
          wmis_d  = wmis_q || last_mis;
          if (wlast) begin
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = (werr_q || wmis_q || last_mis) ? RESP_SLVERR : RESP_OKAY;
            wr_state_d = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          awready_d  = !addr_block;
          wr_state_d = WR_IDLE;
        end
      end

      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      werr_q     <= 1'b0;
      wfixed_q   <= 1'b0;
      wmis_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      wfixed_q   <= wfixed_d;
      wmis_q     <= wmis_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//   Directed, table-driven bench for axi_sram_slave. A table of read/write
//   transactions with hand-computed expectations is replayed in order, then
//   hand-written sequences cover early wlast, W-before-AW, concurrent bursts,
//   same-word collision and reset in the middle of a read burst.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int TMO = 400;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    string       name;
    bit          is_wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] d0;     // write data / expected read data of beat 0
    logic [31:0] step;   // per-beat increment of d0
    bit          chk;    // compare read data
    bit          toggle; // rready 1010...
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, bit w, logic [3:0] id, logic [31:0] a, logic [7:0] l,
                              logic [2:0] sz, logic [1:0] bu, logic [3:0] st, logic [31:0] d,
                              logic [31:0] s, bit c, bit t, logic [1:0] r);
    vec_t v;
    v.name = nm; v.is_wr = w; v.id = id; v.addr = a; v.len = l; v.size = sz; v.burst = bu;
    v.strb = st; v.d0 = d; v.step = s; v.chk = c; v.toggle = t; v.resp = r;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] sz, input logic [1:0] bu, output bit ok);
    int cyc = 0;
    ok = 0;
    arid = id; araddr = a; arlen = l; arsize = sz; arburst = bu; arvalid = 1'b1;
    while (!ok && cyc < TMO) begin
      @(negedge aclk); ok = arready;
      @(posedge aclk); #1; cyc++;
    end
    arvalid = 1'b0;
  endtask

  task automatic aw_issue(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] sz, input logic [1:0] bu, output bit ok);
    int cyc = 0;
    ok = 0;
    awid = id; awaddr = a; awlen = l; awsize = sz; awburst = bu; awvalid = 1'b1;
    while (!ok && cyc < TMO) begin
      @(negedge aclk); ok = awready;
      @(posedge aclk); #1; cyc++;
    end
    awvalid = 1'b0;
  endtask

  task automatic axi_read(input string nm, input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] l, input logic [2:0] sz, input logic [1:0] bu,
                          input bit toggle, input bit chk, input logic [31:0] d0,
                          input logic [31:0] step, input logic [1:0] resp);
    bit ok, held;
    int beat, cyc, lat;
    logic [31:0] hold_data;
    ar_issue(id, a, l, sz, bu, ok);
    if (!ok) begin
      check({nm, "_ar_timeout"}, 32'd0, 32'd1);
      return;
    end
    beat = 0; cyc = 0; lat = -1; held = 0; hold_data = '0;
    while (beat <= int'(l) && cyc < TMO) begin
      rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge aclk);
      if (rvalid && lat < 0) lat = cyc + 1;
      if (held) begin
        check({nm, "_held"}, rdata, hold_data);
        held = 0;
      end
      if (rvalid && rready) begin
        check({nm, "_rid"}, rid, id);
        check({nm, "_rresp"}, rresp, resp);
        check({nm, "_rlast"}, rlast, beat == int'(l));
        if (chk) check({nm, "_rdata"}, rdata, d0 + beat * step);
        beat++;
      end else if (rvalid) begin
        held = 1;
        hold_data = rdata;
      end
      @(posedge aclk); #1; cyc++;
    end
    rready = 1'b0;
    if (beat <= int'(l)) begin
      check({nm, "_r_timeout"}, 32'd0, 32'd1);
      return;
    end
    @(negedge aclk);
    check({nm, "_rvalid_drop"}, rvalid, 1'b0);
`ifndef AXI_SLAVE_STALL_EN
    check({nm, "_latency"}, lat, 1);
`endif
    @(posedge aclk); #1;
  endtask

  task automatic axi_write(input string nm, input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] l, input logic [2:0] sz, input logic [1:0] bu,
                           input logic [3:0] st, input logic [31:0] d0, input logic [31:0] step,
                           input int last_at, input logic [1:0] resp);
    bit ok, got;
    int cyc;
    aw_issue(id, a, l, sz, bu, ok);
    if (!ok) begin
      check({nm, "_aw_timeout"}, 32'd0, 32'd1);
      return;
    end
    for (int b = 0; b <= last_at; b++) begin
      wid = id; wdata = d0 + b * step; wstrb = st; wlast = (b == last_at); wvalid = 1'b1;
      ok = 0; cyc = 0;
      while (!ok && cyc < TMO) begin
        @(negedge aclk); ok = wready;
        @(posedge aclk); #1; cyc++;
      end
      if (!ok) begin
        wvalid = 1'b0; wlast = 1'b0;
        check({nm, "_w_timeout"}, 32'd0, 32'd1);
        return;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1; got = 0; cyc = 0;
    while (!got && cyc < TMO) begin
      @(negedge aclk);
      if (bvalid) begin
        got = 1;
        check({nm, "_bid"}, bid, id);
        check({nm, "_bresp"}, bresp, resp);
      end
      @(posedge aclk); #1; cyc++;
    end
    bready = 1'b0;
    if (!got) check({nm, "_b_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, got;
    int cyc;

    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_arready", arready, 1'b0);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_ids", {rid, bid}, 8'h00);
    check("rst_resps", {rresp, bresp}, 4'h0);
    check("rst_rdata", rdata, 32'h0);

    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rel_arready_before_edge", arready, 1'b0);
    @(posedge aclk); #1;
`ifndef AXI_SLAVE_STALL_EN
    check("rel_arready_first_edge", arready, 1'b1);
    check("rel_awready_first_edge", awready, 1'b1);
`endif

    //               name              wr  id    addr          len    size     burst        strb  d0/exp         step  chk tgl resp
    vecs.push_back(mk("pre_dead",       1, 4'h1, 32'h0000_0400, 8'd0,  SIZE_4B, BURST_INCR,  4'hF, 32'hDEADBEEF, 0,    0,  0,  RESP_OKAY));
    vecs.push_back(mk("rd_single",      0, 4'h3, 32'h0000_0400, 8'd0,  SIZE_4B, BURST_INCR,  4'hF, 32'hDEADBEEF, 0,    1,  0,  RESP_OKAY));
    vecs.push_back(mk("wr_incr4",       1, 4'h2, 32'h0000_1000, 8'd3,  SIZE_4B, BURST_INCR,  4'hF, 32'd1,        1,    0,  0,  RESP_OKAY));
    vecs.push_back(mk("rd_incr4",       0, 4'h4, 32'h0000_1000, 8'd3,  SIZE_4B, BURST_INCR,  4'hF, 32'd1,        1,    1,  0,  RESP_OKAY));
    vecs.push_back(mk("rd_incr4_tgl",   0, 4'h4, 32'h0000_1000, 8'd3,  SIZE_4B, BURST_INCR,  4'hF, 32'd1,        1,    1,  1,  RESP_OKAY));
    vecs.push_back(mk("wr_zero",        1, 4'h0, 32'h0000_0000, 8'd0,  SIZE_4B, BURST_INCR,  4'hF, 32'h0,        0,    0,  0,  RESP_OKAY));
    vecs.push_back(mk("wr_strb",        1, 4'h0, 32'h0000_0000, 8'd0,  SIZE_4B, BURST_INCR,  4'h5, 32'hAABBCCDD, 0,    0,  0,  RESP_OKAY));
    vecs.push_back(mk("rd_strb",        0, 4'h0, 32'h0000_0000, 8'd0,  SIZE_4B, BURST_INCR,  4'hF, 32'h00BB00DD, 0,    1,  0,  RESP_OKAY));
    vecs.push_back(mk("wr_badsize",     1, 4'h8, 32'h0000_1000, 8'd0,  3'b001,  BURST_INCR,  4'hF, 32'hFFFFFFFF, 0,    0,  0,  RESP_SLVERR));
    vecs.push_back(mk("rd_after_bad",   0, 4'h8, 32'h0000_1000, 8'd0,  SIZE_4B, BURST_INCR,  4'hF, 32'd1,        0,    1,  0,  RESP_OKAY));
    vecs.push_back(mk("rd_wrap",        0, 4'hA, 32'h0000_1000, 8'd1,  SIZE_4B, BURST_WRAP,  4'hF, 32'd1,        1,    1,  0,  RESP_SLVERR));
    vecs.push_back(mk("rd_fixed",       0, 4'hB, 32'h0000_1004, 8'd2,  SIZE_4B, BURST_FIXED, 4'hF, 32'd2,        0,    1,  0,  RESP_OKAY));
    vecs.push_back(mk("rd_toolong",     0, 4'hC, 32'h0000_1000, 8'd16, SIZE_4B, BURST_INCR,  4'hF, 32'd0,        0,    0,  0,  RESP_SLVERR));
    vecs.push_back(mk("rd_alias",       0, 4'hD, 32'h0001_0400, 8'd0,  SIZE_4B, BURST_INCR,  4'hF, 32'hDEADBEEF, 0,    1,  0,  RESP_OKAY));
    vecs.push_back(mk("wr_edge",        1, 4'hE, 32'h0000_FFFC, 8'd1,  SIZE_4B, BURST_INCR,  4'hF, 32'h5000,     1,    0,  0,  RESP_OKAY));
    vecs.push_back(mk("rd_edge",        0, 4'hE, 32'h0000_FFFC, 8'd1,  SIZE_4B, BURST_INCR,  4'hF, 32'h5000,     1,    1,  0,  RESP_OKAY));
    vecs.push_back(mk("wr_fixed",       1, 4'h7, 32'h0000_2000, 8'd2,  SIZE_4B, BURST_FIXED, 4'hF, 32'd7,        1,    0,  0,  RESP_OKAY));
    vecs.push_back(mk("rd_fixed_wr",    0, 4'h7, 32'h0000_2000, 8'd0,  SIZE_4B, BURST_INCR,  4'hF, 32'd9,        0,    1,  0,  RESP_OKAY));
    vecs.push_back(mk("wr_toolong",     1, 4'h6, 32'h0000_3000, 8'd16, SIZE_4B, BURST_INCR,  4'hF, 32'h100,      1,    0,  0,  RESP_SLVERR));

    foreach (vecs[i]) begin
      if (vecs[i].is_wr)
        axi_write(vecs[i].name, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size,
                  vecs[i].burst, vecs[i].strb, vecs[i].d0, vecs[i].step,
                  int'(vecs[i].len), vecs[i].resp);
      else
        axi_read(vecs[i].name, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size,
                 vecs[i].burst, vecs[i].toggle, vecs[i].chk, vecs[i].d0, vecs[i].step,
                 vecs[i].resp);
    end

    // wlast on beat 2 of a 4-beat burst: SLVERR, both beats still written.
    axi_write("wr_early_last", 4'h3, 32'h4000, 8'd3, SIZE_4B, BURST_INCR, 4'hF, 32'hA0, 1, 1, RESP_SLVERR);
    axi_read("rd_early_last", 4'h3, 32'h4000, 8'd1, SIZE_4B, BURST_INCR, 0, 1, 32'hA0, 1, RESP_OKAY);

    // W beats before any AW are not accepted.
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("w_before_aw", wready, 1'b0);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;

    // Read and write in flight together, distinct IDs.
    fork
      axi_read("conc_rd", 4'h5, 32'h1000, 8'd3, SIZE_4B, BURST_INCR, 0, 1, 32'd1, 1, RESP_OKAY);
      axi_write("conc_wr", 4'h9, 32'h5000, 8'd3, SIZE_4B, BURST_INCR, 4'hF, 32'h50, 1, 3, RESP_OKAY);
    join
    axi_read("conc_chk", 4'h1, 32'h5000, 8'd3, SIZE_4B, BURST_INCR, 0, 1, 32'h50, 1, RESP_OKAY);

`ifndef AXI_SLAVE_STALL_EN
    // Same-word collision: read and write handshake on the same edge.
    axi_write("col_init", 4'h1, 32'h6000, 8'd0, SIZE_4B, BURST_INCR, 4'hF, 32'h1111_1111, 0, 0, RESP_OKAY);
    aw_issue(4'h7, 32'h6000, 8'd0, SIZE_4B, BURST_INCR, ok);
    check("col_aw_hs", ok, 1'b1);
    wid = 4'h7; wdata = 32'h2222_2222; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'h2; araddr = 32'h6000; arlen = 8'd0; arsize = SIZE_4B; arburst = BURST_INCR; arvalid = 1'b1;
    @(negedge aclk);
    check("col_same_edge", {arready, wready}, 2'b11);
    @(posedge aclk); #1;
    arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; rready = 1'b1; bready = 1'b1;
    @(negedge aclk);
    check("col_rvalid", rvalid, 1'b1);
    check("col_old_data", rdata, 32'h1111_1111);
    check("col_bvalid", bvalid, 1'b1);
    check("col_bresp", bresp, RESP_OKAY);
    @(posedge aclk); #1;
    rready = 1'b0; bready = 1'b0;
    axi_read("col_new", 4'h2, 32'h6000, 8'd0, SIZE_4B, BURST_INCR, 0, 1, 32'h2222_2222, 0, RESP_OKAY);
`endif

    // Reset in the middle of a read burst.
    ar_issue(4'h6, 32'h1000, 8'd3, SIZE_4B, BURST_INCR, ok);
    check("rst_ar_hs", ok, 1'b1);
    rready = 1'b1; got = 0; cyc = 0;
    while (!got && cyc < TMO) begin
      @(negedge aclk); got = rvalid;
      @(posedge aclk); #1; cyc++;
    end
    check("rst_first_beat", got, 1'b1);
    rready = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_rvalid", rvalid, 1'b0);
    check("rst_mid_rlast", rlast, 1'b0);
    check("rst_mid_arready", arready, 1'b0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rst_mid_rel_arready", arready, 1'b0);
    @(posedge aclk); #1;
`ifndef AXI_SLAVE_STALL_EN
    check("rst_mid_arready_edge", arready, 1'b1);
`endif
    axi_read("rst_after", 4'h6, 32'h1000, 8'd3, SIZE_4B, BURST_INCR, 0, 1, 32'd1, 1, RESP_OKAY);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
